qnna_requant_pack: RTL

Output stage directly downstream of the QNNA MAC array. It takes the array's INT32 accumulator results in row-major order and requantizes each one to INT8. Requantization is scale multiply, rounding right shift, zero-point add, optional ReLU and saturation. It packs four INT8 results per 32-bit word and streams the words, with a word address, to the output buffer writer under a valid/ready handshake.

---
 rtl/qnna_requant_pack_if.sv | 24 ++
 rtl/qnna_requant_pack.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/qnna_requant_pack_if.sv
// rtl/qnna_requant_pack_if.sv - accumulator-in / packed-word-out handshake bundle
interface qnna_requant_pack_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [15:0]      out_addr;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_last
  );
endinterface

// File: rtl/qnna_requant_pack.sv
// rtl/qnna_requant_pack.sv - INT32 -> INT8 requantize (scale, round-shift, zp, relu, sat)
// and pack four results per 32-bit word with a word address.
module qnna_requant_pack #(
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16,
  parameter int LANES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        dim_m,
  input  logic [15:0]        dim_n,
  input  logic               relu_en,
  input  logic [SCALE_W-1:0] scale,
  input  logic [4:0]         shift,
  input  logic [7:0]         zero_point,
  qnna_requant_pack_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        sat_count
);
  localparam int PW    = ACC_W + SCALE_W + 1;
  localparam int OUT_W = 8 * LANES;
  localparam logic signed [PW:0] V_MAX = 127;
  localparam logic signed [PW:0] V_MIN = -128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state, state_nx;

  logic               relu_r;
  logic [SCALE_W-1:0] scale_r;
  logic [4:0]         shift_r;
  logic [7:0]         zp_r;
  logic [31:0]        total_r;
  logic [31:0]        elem_cnt;
  logic [1:0]         lane;

  logic                 s1_valid;
  logic                 s1_last;
  logic signed [PW-1:0] s1_prod;

  logic [OUT_W-1:0] pack_buf;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_data_r;
  logic [15:0]      out_addr_r;
  logic             out_last_r;
  logic [15:0]      sat_r;

  logic             in_ready_c;
  logic             adv;
  logic             accept;
  logic             last_elem;
  logic [31:0]      start_total;

  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] rnd_c;
  logic signed [PW-1:0] sum_c;
  logic signed [PW-1:0] shr_c;
  logic signed [PW:0]   v_c;
  logic signed [PW:0]   v_relu;
  logic [7:0]           q_c;
  logic                 clip_c;
  logic [OUT_W-1:0]     word_c;
  logic                 emit_c;

  assign adv         = !(out_valid_r && !bus.out_ready);
  assign accept      = bus.in_valid && in_ready_c;
  assign last_elem   = (elem_cnt == total_r - 32'd1);
  assign start_total = {16'd0, dim_m} * {16'd0, dim_n};
  assign prod_c      = $signed(bus.in_data) * $signed({1'b0, scale_r});

  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (start_total == 32'd0) ? FIN : RUN;
      end
      RUN: begin
        busy       = 1'b1;
        in_ready_c = adv;
        if (accept && last_elem) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_valid_r && bus.out_ready && out_last_r) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Second stage: round-half-up shift, zero point, relu, then saturate to INT8.
  always_comb begin
    rnd_c  = (shift_r == 5'd0) ? '0 : (PW'(1) << (shift_r - 5'd1));
    sum_c  = s1_prod + rnd_c;
    shr_c  = sum_c >>> shift_r;
    v_c    = {shr_c[PW-1], shr_c} + {{(PW + 1 - 8){zp_r[7]}}, zp_r};
    v_relu = (relu_r && v_c[PW]) ? '0 : v_c;
    clip_c = 1'b0;
    q_c    = v_relu[7:0];
    if (v_relu > V_MAX) begin
      q_c    = 8'h7F;
      clip_c = 1'b1;
    end else if (v_relu < V_MIN) begin
      q_c    = 8'h80;
      clip_c = 1'b1;
    end
    word_c                     = pack_buf;
    word_c[{lane, 3'b000} +: 8] = q_c;
    emit_c = (lane == 2'(LANES - 1)) || s1_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      relu_r      <= 1'b0;
      scale_r     <= '0;
      shift_r     <= '0;
      zp_r        <= '0;
      total_r     <= '0;
      elem_cnt    <= '0;
      lane        <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_prod     <= '0;
      pack_buf    <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_addr_r  <= '0;
      out_last_r  <= 1'b0;
      sat_r       <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        relu_r     <= relu_en;
        scale_r    <= scale;
        shift_r    <= shift;
        zp_r       <= zero_point;
        total_r    <= start_total;
        elem_cnt   <= '0;
        lane       <= '0;
        out_addr_r <= '0;
        sat_r      <= '0;
        pack_buf   <= '0;
      end else begin
        if (accept) elem_cnt <= elem_cnt + 32'd1;
        if (out_valid_r && bus.out_ready) out_addr_r <= out_addr_r + 16'd1;
        if (adv) begin
          s1_valid    <= accept;
          s1_prod     <= prod_c;
          s1_last     <= last_elem;
          out_valid_r <= s1_valid && emit_c;
          if (s1_valid) begin
            lane <= lane + 2'd1;
            if (clip_c && sat_r != 16'hFFFF) sat_r <= sat_r + 16'd1;
            if (emit_c) begin
              out_data_r <= word_c;
              out_last_r <= s1_last;
              pack_buf   <= '0;
              lane       <= '0;
            end else begin
              pack_buf <= word_c;
            end
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_last  = out_last_r;
  assign sat_count     = sat_r;
endmodule
